imm_decode_stage: RTL

//  Registered, XLEN-parametrised immediate-decode pipeline stage.

---
 rtl/imm_decode_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate-decode stage between IF/ID and ID/EX with valid/ready and flush.
// Define IMM_SKID_EN to add a skid register so in_ready no longer depends combinationally on out_ready.

module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    entry_t          dec_entry;
    logic            accept;

    assign opcode = in_instr[6:0];

    always_comb begin
        imm32       = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm32   = {in_instr[31:12], 12'b0};
                dec_fmt = FMT_U;
            end
            OP_OPIMM, OP_LOAD, OP_JALR: begin
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_fmt = FMT_I;
            end
            OP_STORE: begin
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec_fmt = FMT_S;
            end
            OP_BRANCH: begin
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            OP_JAL: begin
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
            OP_SYSTEM: begin
                // Only the immediate CSR forms (funct3[2] set) carry a zimm.
                if (in_instr[14]) begin
                    imm32   = {27'b0, in_instr[19:15]};
                    dec_fmt = FMT_Z;
                end
            end
            OP_OP, OP_FENCE: begin
                dec_fmt = FMT_NONE;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // imm32 already holds the correct bit 31 for every format, so widening just replicates it.
    assign dec_imm[31:0] = imm32;
    genvar gi;
    generate
        for (gi = 32; gi < XLEN; gi++) begin : g_sext
            assign dec_imm[gi] = imm32[31];
        end
    endgenerate

    assign dec_entry = '{instr: in_instr, pc: in_pc, imm: dec_imm,
                         fmt: dec_fmt, illegal: dec_illegal};

    entry_t out_q, out_d;
    logic   out_valid_q, out_valid_d;

`ifdef IMM_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    assign in_ready = !reset && !skid_valid_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !reset && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec_entry;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule
